// File: rtl/minesweeper_pkg.sv
// Shared constants and FSM state type for the minesweeper board datapath.
package minesweeper_pkg;

    localparam int GRID_W_DEF = 5;
    localparam int GRID_H_DEF = 5;
    localparam int NUM_CELLS  = GRID_W_DEF * GRID_H_DEF;
    localparam int CNT_W      = 4;

    localparam logic [CNT_W-1:0] MINE_MARK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

endpackage

// File: rtl/neighbor_sum.sv
// Combinational mine count over the up-to-8 in-grid neighbours of one cell.
module neighbor_sum
    import minesweeper_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic [GRID_W*GRID_H-1:0]         mines,
    input  logic [$clog2(GRID_W*GRID_H)-1:0] idx,
    output logic [CNT_W-1:0]                 count
);

    localparam int PW = GRID_W + 2;
    localparam int PH = GRID_H + 2;

    // A zero border around the board makes off-grid neighbours read as empty.
    logic [PW*PH-1:0] padded;

    always_comb begin
        padded = '0;
        for (int r = 0; r < GRID_H; r++) begin
            for (int c = 0; c < GRID_W; c++) begin
                padded[(r + 1) * PW + c + 1] = mines[r * GRID_W + c];
            end
        end
    end

    always_comb begin
        count = '0;
        for (int r = 0; r < GRID_H; r++) begin
            for (int c = 0; c < GRID_W; c++) begin
                if (int'(idx) == r * GRID_W + c) begin
                    for (int dr = 0; dr < 3; dr++) begin
                        for (int dc = 0; dc < 3; dc++) begin
                            if (!(dr == 1 && dc == 1)) begin
                                count = count + CNT_W'(padded[(r + dr) * PW + c + dc]);
                            end
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/neighbor_count.sv
// Sequential scan computing per-cell neighbour mine counts, one cell per cycle.
// Define NEIGHBOR_COUNT_MINE_MARK_EN to report MINE_MARK for cells holding a mine.
module neighbor_count
    import minesweeper_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic                              in_clka,
    input  logic                              in_reset,
    input  logic                              in_start,
    input  logic [GRID_W*GRID_H-1:0]          in_mines,
    output logic [CNT_W*GRID_W*GRID_H-1:0]    out_counts,
    output logic                              out_busy,
    output logic                              out_done
);

    localparam int N_CELLS = GRID_W * GRID_H;
    localparam int IDX_W   = $clog2(N_CELLS);

    state_e                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [N_CELLS-1:0]       mines_q, mines_d;
    logic [CNT_W*N_CELLS-1:0] counts_q, counts_d;
    logic [CNT_W-1:0]         sum;
    logic [CNT_W-1:0]         cell_val;

    neighbor_sum #(
        .GRID_W (GRID_W),
        .GRID_H (GRID_H)
    ) u_neighbor_sum (
        .mines (mines_q),
        .idx   (idx_q),
        .count (sum)
    );

`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
    assign cell_val = mines_q[idx_q] ? MINE_MARK : sum;
`else
    assign cell_val = sum;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mines_d  = mines_q;
        counts_d = counts_q;
        case (state_q)
            IDLE: begin
                if (in_start) begin
                    mines_d  = in_mines;
                    counts_d = '0;
                    idx_d    = '0;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                counts_d[int'(idx_q) * CNT_W +: CNT_W] = cell_val;
                if (idx_q == IDX_W'(N_CELLS - 1)) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge in_clka) begin
        if (in_reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            mines_q  <= '0;
            counts_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mines_q  <= mines_d;
            counts_q <= counts_d;
        end
    end

    assign out_counts = counts_q;
    assign out_busy   = (state_q == SCAN);
    assign out_done   = (state_q == DONE);

endmodule

// File: tb/tb_neighbor_count.sv
// Directed bench for neighbor_count on the default 5x5 board.
module tb_neighbor_count;

    logic         in_clka = 1'b0;
    logic         in_reset;
    logic         in_start;
    logic [24:0]  in_mines;
    logic [99:0]  out_counts;
    logic         out_busy;
    logic         out_done;

    int checks   = 0;
    int failures = 0;

    always #5 in_clka = ~in_clka;

    neighbor_count dut (
        .in_clka    (in_clka),
        .in_reset   (in_reset),
        .in_start   (in_start),
        .in_mines   (in_mines),
        .out_counts (out_counts),
        .out_busy   (out_busy),
        .out_done   (out_done)
    );

`ifdef NEIGHBOR_COUNT_MINE_MARK_EN
    localparam logic [99:0] EXP_M12  = 100'h00000_01110_01F10_01110_00000;
    localparam logic [99:0] EXP_M4   = 100'h00000_00000_00000_11000_F1000;
    localparam logic [99:0] EXP_M20  = 100'h0001F_00011_00000_00000_00000;
    localparam logic [99:0] EXP_ALL  = {25{4'hF}};
    localparam logic [99:0] EXP_MIX  = 100'hF1000_12110_01F10_01121_0001F;
`else
    localparam logic [99:0] EXP_M12  = 100'h00000_01110_01010_01110_00000;
    localparam logic [99:0] EXP_M4   = 100'h00000_00000_00000_11000_01000;
    localparam logic [99:0] EXP_M20  = 100'h00010_00011_00000_00000_00000;
    localparam logic [99:0] EXP_ALL  = 100'h35553_58885_58885_58885_35553;
    localparam logic [99:0] EXP_MIX  = 100'h01000_12110_01010_01121_00010;
`endif

    // Pulse in_start across one edge; returns at the negedge after the start edge.
    task automatic start_scan(input logic [24:0] m);
        @(negedge in_clka);
        in_start = 1'b1;
        in_mines = m;
        @(negedge in_clka);
        in_start = 1'b0;
    endtask

    // Advance negedge by negedge until out_done; cyc = -1 on timeout.
    task automatic wait_done(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (!out_done) begin
            if (out_busy) busy_cyc++;
            if (cyc >= 100) begin
                cyc = -1;
                return;
            end
            @(negedge in_clka);
            cyc++;
        end
    endtask

    task automatic test_reset();
        in_reset = 1'b1;
        in_start = 1'b1;
        in_mines = 25'h1FFFFFF;
        repeat (3) @(negedge in_clka);
        checks++;
        if (out_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", out_busy); end
        checks++;
        if (out_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", out_done); end
        checks++;
        if (out_counts !== 100'h0) begin failures++; $display("FAIL reset_counts got=%h exp=0", out_counts); end
        in_start = 1'b0;
        in_reset = 1'b0;
        @(negedge in_clka);
        checks++;
        if (out_busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy got=%b exp=0", out_busy); end
    endtask

    task automatic test_all_mines();
        int cyc, bcyc;
        start_scan(25'h1FFFFFF);
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 25) begin failures++; $display("FAIL all_latency got=%0d exp=25", cyc); end
        checks++;
        if (out_counts !== EXP_ALL) begin failures++; $display("FAIL all_counts got=%h exp=%h", out_counts, EXP_ALL); end
    endtask

    task automatic test_zero_map();
        int cyc, bcyc;
        start_scan(25'h0);
        checks++;
        if (out_counts !== 100'h0) begin failures++; $display("FAIL zero_clear got=%h exp=0", out_counts); end
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 25) begin failures++; $display("FAIL zero_latency got=%0d exp=25", cyc); end
        checks++;
        if (bcyc != 25) begin failures++; $display("FAIL zero_busy_cycles got=%0d exp=25", bcyc); end
        checks++;
        if (out_counts !== 100'h0) begin failures++; $display("FAIL zero_counts got=%h exp=0", out_counts); end
        @(negedge in_clka);
        checks++;
        if (out_done !== 1'b0) begin failures++; $display("FAIL zero_done_width got=%b exp=0", out_done); end
        checks++;
        if (out_counts !== 100'h0) begin failures++; $display("FAIL zero_hold got=%h exp=0", out_counts); end
    endtask

    task automatic test_single_center();
        int cyc, bcyc;
        start_scan(25'h0001000);
        wait_done(cyc, bcyc);
        checks++;
        if (out_counts !== EXP_M12) begin failures++; $display("FAIL center_counts got=%h exp=%h", out_counts, EXP_M12); end
    endtask

    task automatic test_no_wrap();
        int cyc, bcyc;
        start_scan(25'h0000010);
        wait_done(cyc, bcyc);
        checks++;
        if (out_counts !== EXP_M4) begin failures++; $display("FAIL cell4_counts got=%h exp=%h", out_counts, EXP_M4); end
        start_scan(25'h0100000);
        wait_done(cyc, bcyc);
        checks++;
        if (out_counts !== EXP_M20) begin failures++; $display("FAIL cell20_counts got=%h exp=%h", out_counts, EXP_M20); end
    endtask

    task automatic test_mixed();
        int cyc, bcyc;
        start_scan(25'h1001001);
        wait_done(cyc, bcyc);
        checks++;
        if (out_counts !== EXP_MIX) begin failures++; $display("FAIL mixed_counts got=%h exp=%h", out_counts, EXP_MIX); end
    endtask

    task automatic test_start_ignored();
        int cyc, bcyc;
        start_scan(25'h0001000);
        repeat (5) @(negedge in_clka);
        in_start = 1'b1;
        in_mines = 25'h1FFFFFF;
        repeat (3) @(negedge in_clka);
        in_start = 1'b0;
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 17) begin failures++; $display("FAIL ignore_latency got=%0d exp=17", cyc); end
        checks++;
        if (out_counts !== EXP_M12) begin failures++; $display("FAIL ignore_counts got=%h exp=%h", out_counts, EXP_M12); end
    endtask

    task automatic test_held_start();
        int cyc, bcyc;
        @(negedge in_clka);
        in_start = 1'b1;
        in_mines = 25'h0000010;
        @(negedge in_clka);
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 25) begin failures++; $display("FAIL held_latency got=%0d exp=25", cyc); end
        in_mines = 25'h0100000;
        @(negedge in_clka);
        checks++;
        if (out_busy !== 1'b0) begin failures++; $display("FAIL held_idle_gap got=%b exp=0", out_busy); end
        @(negedge in_clka);
        checks++;
        if (out_busy !== 1'b1) begin failures++; $display("FAIL held_restart got=%b exp=1", out_busy); end
        in_start = 1'b0;
        wait_done(cyc, bcyc);
        checks++;
        if (cyc != 25) begin failures++; $display("FAIL held_second_latency got=%0d exp=25", cyc); end
        checks++;
        if (out_counts !== EXP_M20) begin failures++; $display("FAIL held_second_counts got=%h exp=%h", out_counts, EXP_M20); end
    endtask

    task automatic test_reset_mid_scan();
        int done_seen;
        done_seen = 0;
        start_scan(25'h1FFFFFF);
        repeat (9) @(negedge in_clka);
        in_reset = 1'b1;
        @(negedge in_clka);
        in_reset = 1'b0;
        checks++;
        if (out_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy got=%b exp=0", out_busy); end
        checks++;
        if (out_counts !== 100'h0) begin failures++; $display("FAIL midreset_counts got=%h exp=0", out_counts); end
        repeat (30) begin
            if (out_done) done_seen++;
            @(negedge in_clka);
        end
        checks++;
        if (done_seen != 0) begin failures++; $display("FAIL midreset_no_done got=%0d exp=0", done_seen); end
    endtask

    initial begin
        in_reset = 1'b1;
        in_start = 1'b0;
        in_mines = '0;
        test_reset();
        test_all_mines();
        test_zero_map();
        test_single_center();
        test_no_wrap();
        test_mixed();
        test_start_ignored();
        test_held_start();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
